// File: rtl/lsu_sized_pkg.sv
// Address map, access-size encodings and lane helpers shared by the sized load/store unit.
package lsu_pkg;

    localparam logic [31:0] DMEM_BASE    = 32'h0000_2000;
    localparam logic [31:0] LEDR_ADDR    = 32'h0000_7000;
    localparam logic [31:0] LEDG_ADDR    = 32'h0000_7010;
    localparam logic [31:0] HEX_BASE     = 32'h0000_7020;
    localparam logic [31:0] LCD_ADDR     = 32'h0000_7030;
    localparam logic [31:0] SW_ADDR      = 32'h0000_7800;
    localparam logic [31:0] BTN_ADDR     = 32'h0000_7810;
    localparam logic [31:0] BTN_CLR_ADDR = 32'h0000_7814;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        W_BYTE,
        W_HALF,
        W_WORD
    } width_e;

    // Undefined funct3 codes fall through to a word access.
    function automatic width_e size_width(input logic [2:0] f3);
        width_e w;
        case (f3)
            SZ_B, SZ_BU: w = W_BYTE;
            SZ_H, SZ_HU: w = W_HALF;
            default:     w = W_WORD;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] lane_mask(input width_e w, input logic [1:0] off);
        logic [3:0] m;
        case (w)
            W_BYTE:  m = 4'b0001 << off;
            W_HALF:  m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] replicate_store(input width_e w, input logic [31:0] d);
        logic [31:0] r;
        case (w)
            W_BYTE:  r = {4{d[7:0]}};
            W_HALF:  r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int unsigned l = 0; l < 4; l++) begin
            r[8*l +: 8] = be[l] ? new_w[8*l +: 8] : old_w[8*l +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] w,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size_width(f3))
            W_BYTE:  r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            W_HALF:  r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_sized_if.sv
// Request/response bus between a core pipeline and the sized load/store unit.
interface lsu_sized_if;
    logic        i_req;
    logic        i_wren;
    logic [31:0] i_addr;
    logic [2:0]  i_size;
    logic [31:0] i_st_data;
    logic [31:0] o_ld_data;
    logic        o_ld_valid;
    logic        o_misalign;

    modport master (
        output i_req, i_wren, i_addr, i_size, i_st_data,
        input  o_ld_data, o_ld_valid, o_misalign
    );

    modport slave (
        input  i_req, i_wren, i_addr, i_size, i_st_data,
        output o_ld_data, o_ld_valid, o_misalign
    );
endinterface

// File: rtl/lsu_sized_sync.sv
// Multi-flop synchroniser for asynchronous switch/button inputs.
module lsu_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/lsu_sized.sv
// Sized load/store unit: byte-lane DMEM plus memory-mapped LED/HEX/LCD/switch/button IO.
module lsu_sized
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_WORDS  = 2048,
    parameter int unsigned NUM_HEX     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    lsu_sized_if.slave         bus,
    input  logic [31:0]        i_io_sw,
    input  logic [3:0]         i_io_btn,
    output logic [31:0]        o_io_ledr,
    output logic [31:0]        o_io_ledg,
    output logic [31:0]        o_io_lcd,
    output logic [7*NUM_HEX-1:0] o_io_hex
);

    localparam int unsigned IDX_W = $clog2(DMEM_WORDS);

    logic [3:0][7:0] dmem_q [DMEM_WORDS];

    logic [31:0] ledr_q, ledr_d;
    logic [31:0] ledg_q, ledg_d;
    logic [31:0] lcd_q, lcd_d;
    logic [6:0]  hex_q [NUM_HEX];
    logic [6:0]  hex_d [NUM_HEX];
    logic [3:0]  sticky_q, sticky_d;
    logic [3:0]  btn_prev_q;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;
    logic        misalign_q, misalign_d;

    logic [31:0] sw_sync;
    logic [3:0]  btn_sync;

    lsu_sync #(.WIDTH(32), .STAGES(SYNC_STAGES)) u_sync_sw (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_io_sw),
        .o_q     (sw_sync)
    );

    lsu_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_io_btn),
        .o_q     (btn_sync)
    );

    width_e       acc_w;
    logic [1:0]   off;
    logic         mis;
    logic         is_load, is_store;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic [29:0]  dmem_word;
    logic [IDX_W-1:0] idx;
    logic         in_dmem;
    logic         hit_ledr, hit_ledg, hit_lcd, hit_sw, hit_btn, hit_btnclr;
    logic [NUM_HEX-1:0] hit_hex;
    logic [31:0]  rd_word;
    logic [3:0]   rise, clr;

    always_comb begin
        acc_w    = size_width(bus.i_size);
        off      = bus.i_addr[1:0];
        mis      = ((acc_w == W_HALF) && off[0]) || ((acc_w == W_WORD) && (off != 2'b00));
        is_load  = bus.i_req && !mis && !bus.i_wren;
        is_store = bus.i_req && !mis &&  bus.i_wren;
        be       = lane_mask(acc_w, off);
        wdata    = replicate_store(acc_w, bus.i_st_data);

        dmem_word = bus.i_addr[31:2] - DMEM_BASE[31:2];
        in_dmem   = (bus.i_addr >= DMEM_BASE) && (dmem_word[29:IDX_W] == '0);
        idx       = dmem_word[IDX_W-1:0];

        hit_ledr   = bus.i_addr[31:2] == LEDR_ADDR[31:2];
        hit_ledg   = bus.i_addr[31:2] == LEDG_ADDR[31:2];
        hit_lcd    = bus.i_addr[31:2] == LCD_ADDR[31:2];
        hit_sw     = bus.i_addr[31:2] == SW_ADDR[31:2];
        hit_btn    = bus.i_addr[31:2] == BTN_ADDR[31:2];
        hit_btnclr = bus.i_addr[31:2] == BTN_CLR_ADDR[31:2];
        // The HEX window overlaps 0x7030; the LCD register owns that word.
        for (int unsigned i = 0; i < NUM_HEX; i++) begin
            hit_hex[i] = !hit_lcd && (bus.i_addr[31:2] == HEX_BASE[31:2] + 30'(i));
        end
    end

    always_comb begin
        rd_word = '0;
        if (in_dmem)         rd_word = dmem_q[idx];
        else if (hit_ledr)   rd_word = ledr_q;
        else if (hit_ledg)   rd_word = ledg_q;
        else if (hit_lcd)    rd_word = lcd_q;
        else if (hit_sw)     rd_word = sw_sync;
        else if (hit_btn)    rd_word = {24'b0, sticky_q, btn_sync};
        else begin
            for (int unsigned i = 0; i < NUM_HEX; i++) begin
                if (hit_hex[i]) rd_word = {25'b0, hex_q[i]};
            end
        end
    end

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        lcd_d  = lcd_q;
        for (int unsigned i = 0; i < NUM_HEX; i++) begin
            hex_d[i] = hex_q[i];
        end
        if (is_store) begin
            if (hit_ledr) ledr_d = merge_lanes(ledr_q, wdata, be);
            if (hit_ledg) ledg_d = merge_lanes(ledg_q, wdata, be);
            if (hit_lcd)  lcd_d  = merge_lanes(lcd_q,  wdata, be);
            for (int unsigned i = 0; i < NUM_HEX; i++) begin
                if (hit_hex[i] && be[0]) hex_d[i] = wdata[6:0];
            end
        end

        // A rising edge wins over a same-cycle clear of that bit.
        rise     = btn_sync & ~btn_prev_q;
        clr      = (is_store && hit_btnclr) ? (wdata[3:0] & {4{be[0]}}) : 4'b0000;
        sticky_d = (sticky_q & ~clr) | rise;

        ld_data_d  = is_load ? extract_load(rd_word, off, bus.i_size) : ld_data_q;
        ld_valid_d = is_load;
        misalign_d = bus.i_req && mis;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            lcd_q      <= '0;
            for (int unsigned i = 0; i < NUM_HEX; i++) begin
                hex_q[i] <= '0;
            end
            sticky_q   <= '0;
            btn_prev_q <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            lcd_q      <= lcd_d;
            for (int unsigned i = 0; i < NUM_HEX; i++) begin
                hex_q[i] <= hex_d[i];
            end
            sticky_q   <= sticky_d;
            btn_prev_q <= btn_sync;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (is_store && in_dmem) begin
            for (int unsigned l = 0; l < 4; l++) begin
                if (be[l]) dmem_q[idx][l] <= wdata[8*l +: 8];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_HEX; i++) begin
            o_io_hex[7*i +: 7] = hex_q[i];
        end
    end

    assign o_io_ledr      = ledr_q;
    assign o_io_ledg      = ledg_q;
    assign o_io_lcd       = lcd_q;
    assign bus.o_ld_data  = ld_data_q;
    assign bus.o_ld_valid = ld_valid_q;
    assign bus.o_misalign = misalign_q;

endmodule

// File: tb/tb_lsu_sized.sv
// Directed self-checking bench for lsu_sized.
module tb_lsu_sized;

    logic        clk;
    logic        rst_n;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [31:0] ledr, ledg, lcd;
    logic [55:0] hex;

    int pass_cnt = 0;
    int total_cnt = 0;

    lsu_sized_if bus();

    lsu_sized #(.DMEM_WORDS(2048), .NUM_HEX(8), .SYNC_STAGES(2)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus),
        .i_io_sw   (io_sw),
        .i_io_btn  (io_btn),
        .o_io_ledr (ledr),
        .o_io_ledg (ledg),
        .o_io_lcd  (lcd),
        .o_io_hex  (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access on a falling edge; returns on the falling edge after acceptance.
    task automatic acc(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wren = wr; bus.i_addr = a; bus.i_size = sz; bus.i_st_data = d;
        @(negedge clk);
        bus.i_req = 1'b0; bus.i_wren = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.o_ld_valid !== 1'b0) $display("FAIL reset_ld_valid got=%b exp=0", bus.o_ld_valid); else pass_cnt++;
        total_cnt++; if (bus.o_misalign !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", bus.o_misalign); else pass_cnt++;
        total_cnt++; if (bus.o_ld_data !== 32'h0) $display("FAIL reset_ld_data got=%h exp=0", bus.o_ld_data); else pass_cnt++;
        total_cnt++; if ({ledr, ledg, lcd} !== 96'h0) $display("FAIL reset_leds got=%h exp=0", {ledr, ledg, lcd}); else pass_cnt++;
        total_cnt++; if (hex !== 56'h0) $display("FAIL reset_hex got=%h exp=0", hex); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        acc(1'b1, 32'h2004, 3'b010, 32'hDEADBEEF);
        total_cnt++; if (bus.o_ld_valid !== 1'b0) $display("FAIL store_no_valid got=%b exp=0", bus.o_ld_valid); else pass_cnt++;
        acc(1'b0, 32'h2004, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_valid !== 1'b1) $display("FAIL lw_valid got=%b exp=1", bus.o_ld_valid); else pass_cnt++;
        total_cnt++; if (bus.o_ld_data !== 32'hDEADBEEF) $display("FAIL lw_data got=%h exp=deadbeef", bus.o_ld_data); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.o_ld_valid !== 1'b0) $display("FAIL lw_valid_pulse got=%b exp=0", bus.o_ld_valid); else pass_cnt++;
        total_cnt++; if (bus.o_ld_data !== 32'hDEADBEEF) $display("FAIL lw_data_hold got=%h exp=deadbeef", bus.o_ld_data); else pass_cnt++;
    endtask

    task automatic test_sized;
        acc(1'b1, 32'h2007, 3'b000, 32'h00000080);
        acc(1'b0, 32'h2007, 3'b000, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'hFFFFFF80) $display("FAIL lb got=%h exp=ffffff80", bus.o_ld_data); else pass_cnt++;
        acc(1'b0, 32'h2007, 3'b100, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h00000080) $display("FAIL lbu got=%h exp=00000080", bus.o_ld_data); else pass_cnt++;
        acc(1'b0, 32'h2004, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h80ADBEEF) $display("FAIL lw_after_sb got=%h exp=80adbeef", bus.o_ld_data); else pass_cnt++;
        acc(1'b0, 32'h2006, 3'b001, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'hFFFF80AD) $display("FAIL lh_hi got=%h exp=ffff80ad", bus.o_ld_data); else pass_cnt++;
        acc(1'b0, 32'h2006, 3'b101, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h000080AD) $display("FAIL lhu_hi got=%h exp=000080ad", bus.o_ld_data); else pass_cnt++;
        acc(1'b0, 32'h2004, 3'b001, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'hFFFFBEEF) $display("FAIL lh_lo got=%h exp=ffffbeef", bus.o_ld_data); else pass_cnt++;
        acc(1'b0, 32'h2005, 3'b000, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'hFFFFFFBE) $display("FAIL lb_lane1 got=%h exp=ffffffbe", bus.o_ld_data); else pass_cnt++;
        acc(1'b1, 32'h2008, 3'b011, 32'h11223344);
        acc(1'b0, 32'h2008, 3'b111, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h11223344) $display("FAIL undef_size_word got=%h exp=11223344", bus.o_ld_data); else pass_cnt++;
    endtask

    task automatic test_misalign;
        acc(1'b0, 32'h2002, 3'b010, 32'h0);
        total_cnt++; if (bus.o_misalign !== 1'b1) $display("FAIL lw_misalign got=%b exp=1", bus.o_misalign); else pass_cnt++;
        total_cnt++; if (bus.o_ld_valid !== 1'b0) $display("FAIL lw_misalign_valid got=%b exp=0", bus.o_ld_valid); else pass_cnt++;
        total_cnt++; if (bus.o_ld_data !== 32'h11223344) $display("FAIL misalign_data_held got=%h exp=11223344", bus.o_ld_data); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.o_misalign !== 1'b0) $display("FAIL misalign_pulse got=%b exp=0", bus.o_misalign); else pass_cnt++;
        acc(1'b1, 32'h2001, 3'b001, 32'h00001234);
        total_cnt++; if (bus.o_misalign !== 1'b1) $display("FAIL sh_misalign got=%b exp=1", bus.o_misalign); else pass_cnt++;
        acc(1'b0, 32'h2000, 3'b010, 32'h0);
        acc(1'b0, 32'h2004, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h80ADBEEF) $display("FAIL sh_misalign_nochange got=%h exp=80adbeef", bus.o_ld_data); else pass_cnt++;
        acc(1'b0, 32'h200A, 3'b011, 32'h0);
        total_cnt++; if (bus.o_misalign !== 1'b1) $display("FAIL undef_size_misalign got=%b exp=1", bus.o_misalign); else pass_cnt++;
    endtask

    task automatic test_io;
        acc(1'b1, 32'h702C, 3'b010, 32'h0000007F);
        total_cnt++; if (hex !== 56'h00_0000_0FE0_0000) $display("FAIL hex3 got=%h exp=00000000fe00000", hex); else pass_cnt++;
        acc(1'b1, 32'h7020, 3'b010, 32'hFFFFFF05);
        total_cnt++; if (hex !== 56'h00_0000_0FE0_0005) $display("FAIL hex0_low7 got=%h exp=00000000fe00005", hex); else pass_cnt++;
        acc(1'b1, 32'h7000, 3'b010, 32'h12345678);
        acc(1'b1, 32'h7012, 3'b000, 32'h000000AA);
        acc(1'b1, 32'h7032, 3'b001, 32'h0000BEEF);
        total_cnt++; if (ledr !== 32'h12345678) $display("FAIL ledr got=%h exp=12345678", ledr); else pass_cnt++;
        total_cnt++; if (ledg !== 32'h00AA0000) $display("FAIL ledg_sb got=%h exp=00aa0000", ledg); else pass_cnt++;
        total_cnt++; if (lcd !== 32'hBEEF0000) $display("FAIL lcd_sh got=%h exp=beef0000", lcd); else pass_cnt++;
        acc(1'b0, 32'h7001, 3'b100, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h00000056) $display("FAIL ledr_lbu got=%h exp=00000056", bus.o_ld_data); else pass_cnt++;
        acc(1'b1, 32'h7800, 3'b010, 32'h0);
        acc(1'b0, 32'h7800, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'hCAFEF00D) $display("FAIL sw_read got=%h exp=cafef00d", bus.o_ld_data); else pass_cnt++;
        acc(1'b1, 32'h5000, 3'b010, 32'hFFFFFFFF);
        acc(1'b0, 32'h5000, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_valid !== 1'b1 || bus.o_ld_data !== 32'h0) $display("FAIL unmapped_ld got=%b/%h exp=1/00000000", bus.o_ld_valid, bus.o_ld_data); else pass_cnt++;
        acc(1'b0, 32'h4000, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_valid !== 1'b1 || bus.o_ld_data !== 32'h0) $display("FAIL dmem_oob_ld got=%b/%h exp=1/00000000", bus.o_ld_valid, bus.o_ld_data); else pass_cnt++;
        total_cnt++; if ({ledr, ledg, lcd} !== {32'h12345678, 32'h00AA0000, 32'hBEEF0000}) $display("FAIL io_untouched got=%h", {ledr, ledg, lcd}); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wren = 1'b1; bus.i_addr = 32'h2010; bus.i_size = 3'b010; bus.i_st_data = 32'h55AA33CC;
        @(negedge clk);
        bus.i_wren = 1'b0; bus.i_st_data = 32'h0;
        @(negedge clk);
        bus.i_req = 1'b0;
        total_cnt++; if (bus.o_ld_valid !== 1'b1 || bus.o_ld_data !== 32'h55AA33CC) $display("FAIL b2b_st_ld got=%b/%h exp=1/55aa33cc", bus.o_ld_valid, bus.o_ld_data); else pass_cnt++;
    endtask

    task automatic test_btn;
        @(negedge clk); io_btn = 4'b0100;
        repeat (3) @(negedge clk);
        io_btn = 4'b0000;
        repeat (4) @(negedge clk);
        acc(1'b0, 32'h7810, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h00000040) $display("FAIL btn_sticky got=%h exp=00000040", bus.o_ld_data); else pass_cnt++;
        acc(1'b1, 32'h7814, 3'b010, 32'h00000004);
        acc(1'b0, 32'h7810, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h00000000) $display("FAIL btn_clear got=%h exp=00000000", bus.o_ld_data); else pass_cnt++;
        // Edge reaches the second sync stage on the edge before the clear is accepted.
        io_btn = 4'b0100;
        @(negedge clk);
        acc(1'b1, 32'h7814, 3'b010, 32'h00000004);
        acc(1'b0, 32'h7810, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h00000044) $display("FAIL btn_edge_vs_clear got=%h exp=00000044", bus.o_ld_data); else pass_cnt++;
        io_btn = 4'b0000;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wren = 1'b0; bus.i_addr = 32'h2004; bus.i_size = 3'b010;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if ({ledr, ledg, lcd} !== 96'h0 || hex !== 56'h0) $display("FAIL rst_async_io got=%h/%h exp=0", {ledr, ledg, lcd}, hex); else pass_cnt++;
        total_cnt++; if (bus.o_ld_data !== 32'h0) $display("FAIL rst_async_ld_data got=%h exp=0", bus.o_ld_data); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus.o_ld_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", bus.o_ld_valid); else pass_cnt++;
        @(negedge clk);
        bus.i_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.o_ld_valid !== 1'b0 || bus.o_misalign !== 1'b0) $display("FAIL rst_release_cancel got=%b/%b exp=0/0", bus.o_ld_valid, bus.o_misalign); else pass_cnt++;
        acc(1'b0, 32'h2004, 3'b010, 32'h0);
        total_cnt++; if (bus.o_ld_data !== 32'h80ADBEEF) $display("FAIL dmem_survives_rst got=%h exp=80adbeef", bus.o_ld_data); else pass_cnt++;
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_wren = 1'b0; bus.i_addr = '0; bus.i_size = '0; bus.i_st_data = '0;
        io_sw  = 32'hCAFEF00D;
        io_btn = 4'b0000;
        test_reset;
        test_word;
        test_sized;
        test_misalign;
        test_io;
        test_back_to_back;
        test_btn;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_sized.md
LSU_SIZED -- requirements
Module: lsu_sized

Interface
REQ-001 Parameter DMEM_WORDS, default 2048, data-memory depth in 32-bit words (power of two).
REQ-002 Parameter NUM_HEX, default 8, number of 7-segment digit registers (1..8).
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth for switch/button inputs (>=2).
REQ-004 Port i_clk  in  1  sole clock, all state on rising edge.
REQ-005 Port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port i_req  in  1  access request valid this cycle.
REQ-007 Port i_wren  in  1  1 = store, 0 = load (qualified by i_req).
REQ-008 Port i_addr  in  32  byte address.
REQ-009 Port i_size  in  3  RV32 funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-010 Port i_st_data  in  32  store data, right-aligned.
REQ-011 Port i_io_sw / i_io_btn  in  32 / 4  raw asynchronous switches / buttons.
REQ-012 Port o_ld_data / o_ld_valid  out  32 / 1  load result and its one-cycle strobe.
REQ-013 Port o_misalign  out  1  one-cycle pulse flagging a rejected misaligned access.
REQ-014 Port o_io_ledr / o_io_ledg / o_io_lcd  out  32 each  LED and LCD registers.
REQ-015 Port o_io_hex  out  7*NUM_HEX  digit i in bits [7i+6:7i].

Function
REQ-016 Map: DMEM 0x2000..0x2000+4*DMEM_WORDS-1; LEDR 0x7000; LEDG 0x7010; HEX i at 0x7020+4i; LCD 0x7030; SW 0x7800 (RO); BTN 0x7810 (RO); BTN_CLR 0x7814 (W1C).
REQ-017 Access accepted only when i_req=1; every accepted access completes, no back-pressure.
REQ-018 Misaligned = halfword with addr[0]=1 or word with addr[1:0]!=0; such access SHALL change no state, pulse o_misalign next cycle, not assert o_ld_valid.
REQ-019 Stores SHALL write only addressed byte lanes (SB one lane at addr[1:0], SH two, SW four) into DMEM or the 32-bit IO register.
REQ-020 HEX registers hold bits [6:0] of the written word; lanes above bit 6 ignored.
REQ-021 Stores to RO, unmapped, or out-of-range addresses SHALL be ignored silently.
REQ-022 Load latency exactly 1 cycle: o_ld_valid=1 in cycle after acceptance, o_ld_data valid then and held until next load completes.
REQ-023 Load extraction: byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; LW unmodified.
REQ-024 Unmapped loads return 0 with o_ld_valid=1.
REQ-025 Load after store to same address in next cycle SHALL return stored data (no hazard).
REQ-026 SW read returns SYNC_STAGES-flop synchronised i_io_sw.
REQ-027 BTN read returns {24'b0, sticky[3:0], synced[3:0]}; sticky bit sets on synchronised rising edge.
REQ-028 Write to BTN_CLR clears sticky bits where i_st_data[3:0]=1; simultaneous edge and clear -> bit stays set.
REQ-029 Undefined i_size codes (011,110,111) treated as word access.

Reset
REQ-030 i_rst_n=0 SHALL immediately clear LEDR, LEDG, LCD, all HEX, sticky, synchronisers, o_ld_data, o_ld_valid, o_misalign.
REQ-031 Reset mid-access SHALL cancel it: no o_ld_valid or o_misalign after release.
REQ-032 DMEM contents not reset.

Structure
REQ-033 Package lsu_pkg holds address-map constants and funct3 size enum.
REQ-034 One sub-module, lsu_sync (SYNC_STAGES-deep synchroniser, parametrised width), instanced for SW and BTN.

Verification
REQ-035 SW 0xDEADBEEF to 0x2004, LW 0x2004 -> o_ld_valid one cycle later, data 0xDEADBEEF.
REQ-036 SB 0x80 to 0x2007, LB 0x2007 -> 0xFFFFFF80; LBU -> 0x00000080; LW 0x2004 -> 0x80ADBEEF.
REQ-037 LW 0x2002 -> o_misalign pulse, no o_ld_valid; SH 0x2001 -> DMEM unchanged.
REQ-038 SW 0x7F to 0x702C -> o_io_hex digit 3 = 0x7F, other digits 0.
REQ-039 Pulse i_io_btn[2], then read 0x7810 -> bit 6 set; write 0x4 to 0x7814 same cycle as new edge -> bit 6 remains set.
REQ-040 Assert i_rst_n=0 during load cycle -> o_ld_valid stays 0, all IO outputs 0 asynchronously.
